// File: rtl/facache_ctrl_pkg.sv
// facache_ctrl_pkg: shared state encoding, port ids and counter helpers for the cache controller
package facache_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_CHECK   = 3'd2,
    S_MEMREQ  = 3'd3,
    S_MEMWAIT = 3'd4,
    S_FILL    = 3'd5
  } state_t;
  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return v == CNT_MAX ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/facache_ctrl_arb.sv
// rr_arb2: two-requester round-robin arbiter; port 0 wins the first contested grant after reset
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);
  logic r_last;
  always_comb grant = req == 2'b11 ? (r_last ? 2'b01 : 2'b10) : req;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_last <= 1'b1;
    else if (advance && |grant) r_last <= grant[1];
endmodule

// File: rtl/facache_ctrl.sv
// facache_ctrl: serialises two read ports onto the LRU cache, filling misses from backing memory
module facache_ctrl
  import facache_ctrl_pkg::*;
#(
  parameter int DEBUG = 0,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_adr,
  output logic         req0_ready,
  output logic         resp0_valid,
  output logic [W-1:0] resp0_data,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_adr,
  output logic         req1_ready,
  output logic         resp1_valid,
  output logic [W-1:0] resp1_data,
  output logic [W-1:0] c_adr,
  output logic         c_readEnable,
  output logic [W-1:0] c_insert_adr,
  output logic [W-1:0] c_data_in,
  output logic         c_valid_in,
  input  logic [W-1:0] c_data_out,
  input  logic         c_valid_out,
  output logic         mem_req_valid,
  output logic [W-1:0] mem_req_adr,
  input  logic         mem_req_ready,
  input  logic         mem_resp_valid,
  input  logic [W-1:0] mem_resp_data,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
);
  state_t       r_state;
  logic         r_id, r_resp0_valid, r_resp1_valid;
  logic [W-1:0] r_adr, r_data, r_resp0_data, r_resp1_data;
  logic [15:0]  r_hit_cnt, r_miss_cnt;
  logic [1:0]   w_grant;
  logic         w_idle, w_hit, w_resp;
  logic [W-1:0] w_rdata;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({req1_valid, req0_valid}),
    .advance(w_idle),
    .grant  (w_grant)
  );

  always_comb begin
    w_idle  = r_state == S_IDLE;
    w_hit   = r_state == S_CHECK && c_valid_out;
    w_resp  = w_hit || r_state == S_FILL;
    w_rdata = w_hit ? c_data_out : r_data;
  end

  assign req0_ready    = w_idle && w_grant[0];
  assign req1_ready    = w_idle && w_grant[1];
  assign resp0_valid   = r_resp0_valid;
  assign resp0_data    = r_resp0_data;
  assign resp1_valid   = r_resp1_valid;
  assign resp1_data    = r_resp1_data;
  assign c_adr         = r_adr;
  assign c_readEnable  = r_state == S_ISSUE;
  assign c_insert_adr  = r_adr;
  assign c_data_in     = r_data;
  assign c_valid_in    = r_state == S_FILL;
  assign mem_req_valid = r_state == S_MEMREQ;
  assign mem_req_adr   = r_adr;
  assign hit_count     = r_hit_cnt;
  assign miss_count    = r_miss_cnt;

  // cache/memory handshakes are only sampled in their own state, so stale or late strobes are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_id          <= P0;
      r_adr         <= '0;
      r_data        <= '0;
      r_resp0_valid <= 1'b0;
      r_resp1_valid <= 1'b0;
      r_resp0_data  <= '0;
      r_resp1_data  <= '0;
      r_hit_cnt     <= '0;
      r_miss_cnt    <= '0;
    end else begin
      r_resp0_valid <= w_resp && r_id == P0;
      r_resp1_valid <= w_resp && r_id == P1;
      if (w_resp && r_id == P0) r_resp0_data <= w_rdata;
      if (w_resp && r_id == P1) r_resp1_data <= w_rdata;
      case (r_state)
        S_IDLE: if (|w_grant) begin
          r_adr   <= w_grant[1] ? req1_adr : req0_adr;
          r_id    <= w_grant[1] ? P1 : P0;
          r_state <= S_ISSUE;
        end
        S_ISSUE: r_state <= S_CHECK;
        S_CHECK: begin
          r_state <= c_valid_out ? S_IDLE : S_MEMREQ;
          if (c_valid_out) r_hit_cnt <= sat_inc(r_hit_cnt);
        end
        S_MEMREQ: if (mem_req_ready) r_state <= S_MEMWAIT;
        S_MEMWAIT: if (mem_resp_valid) begin
          r_data  <= mem_resp_data;
          r_state <= S_FILL;
        end
        S_FILL: begin
          r_miss_cnt <= sat_inc(r_miss_cnt);
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  if (DEBUG != 0) begin : g_debug
  end
endmodule

// File: tb/tb_facache_ctrl.sv
// tb_facache_ctrl: directed and randomized checks of facache_ctrl against an LRU cache and memory model
module tb_facache_ctrl;
  logic        clk = 0, rst_n = 0;
  logic        req0_valid = 0, req1_valid = 0;
  logic [15:0] req0_adr = 0, req1_adr = 0;
  logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
  logic [15:0] resp0_data, resp1_data;
  logic [15:0] c_adr, c_insert_adr, c_data_in;
  logic        c_readEnable, c_valid_in;
  logic [15:0] c_data_out = 0;
  logic        c_valid_out = 0;
  logic        mem_req_valid, mem_req_ready, mem_resp_valid;
  logic [15:0] mem_req_adr, mem_resp_data;
  logic [15:0] hit_count, miss_count;

  facache_ctrl #(.DEBUG(0), .W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_adr(req0_adr), .req0_ready(req0_ready),
    .resp0_valid(resp0_valid), .resp0_data(resp0_data),
    .req1_valid(req1_valid), .req1_adr(req1_adr), .req1_ready(req1_ready),
    .resp1_valid(resp1_valid), .resp1_data(resp1_data),
    .c_adr(c_adr), .c_readEnable(c_readEnable), .c_insert_adr(c_insert_adr),
    .c_data_in(c_data_in), .c_valid_in(c_valid_in),
    .c_data_out(c_data_out), .c_valid_out(c_valid_out),
    .mem_req_valid(mem_req_valid), .mem_req_adr(mem_req_adr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int exp_hit = 0, exp_miss = 0;
  int n_memreq = 0, n_ins = 0, n_r0 = 0, n_r1 = 0, excl = 0, n_stall = 0, stab_err = 0;
  logic [15:0] last_mreq_adr = 0, last_ins_adr = 0, last_ins_dat = 0, last_r0 = 0, last_r1 = 0;

  function automatic logic [15:0] memval(input logic [15:0] a);
    logic [15:0] m;
    m = a * 16'h2F1B;
    return a == 16'h0040 ? 16'hBEEF : m ^ 16'h6D3C;
  endfunction

  function automatic int sat(input int v);
    return v >= 65535 ? 65535 : v + 1;
  endfunction

  // LRU cache stub: index 0 is least recently used; contents are not affected by controller reset
  logic [15:0] cq_adr[$], cq_dat[$];
  function automatic int cfind(input logic [15:0] a);
    foreach (cq_adr[i]) if (cq_adr[i] == a) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    int k;
    logic [15:0] d;
    if (c_readEnable && c_valid_in) excl++;
    if (c_readEnable) begin
      k = cfind(c_adr);
      c_valid_out <= k >= 0;
      c_data_out  <= 16'hDEAD;
      if (k >= 0) begin
        d = cq_dat[k];
        c_data_out <= d;
        cq_adr.delete(k); cq_dat.delete(k);
        cq_adr.push_back(c_adr); cq_dat.push_back(d);
      end
    end
    if (c_valid_in) begin
      k = cfind(c_insert_adr);
      if (k >= 0) begin
        cq_adr.delete(k); cq_dat.delete(k);
      end else if (cq_adr.size() == 4) begin
        void'(cq_adr.pop_front()); void'(cq_dat.pop_front());
      end
      cq_adr.push_back(c_insert_adr); cq_dat.push_back(c_data_in);
      n_ins++; last_ins_adr = c_insert_adr; last_ins_dat = c_data_in;
    end
  end

  // memory stub: ready after `stall` waiting cycles, data one cycle after the handshake
  int stall = 0, wcnt = 0;
  bit mute = 0;
  logic m_valid = 0, inj_valid = 0;
  logic [15:0] m_data = 0, inj_data = 0;
  logic pw = 0;
  logic [15:0] pa = 0;
  assign mem_req_ready  = mem_req_valid && wcnt >= stall;
  assign mem_resp_valid = m_valid | inj_valid;
  assign mem_resp_data  = inj_valid ? inj_data : m_data;

  always @(posedge clk) begin
    wcnt    <= (mem_req_valid && !mem_req_ready) ? wcnt + 1 : 0;
    m_valid <= mem_req_valid && mem_req_ready && !mute;
    m_data  <= memval(mem_req_adr);
    if (mem_req_valid && mem_req_ready) begin
      n_memreq++; last_mreq_adr = mem_req_adr;
    end
    if (pw) begin
      n_stall++;
      if (!mem_req_valid || mem_req_adr != pa || c_readEnable || c_valid_in) stab_err++;
    end
    pw <= mem_req_valid && !mem_req_ready;
    pa <= mem_req_adr;
  end

  always @(negedge clk) begin
    if (resp0_valid) begin n_r0++; last_r0 = resp0_data; end
    if (resp1_valid) begin n_r1++; last_r1 = resp1_data; end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1; exp_hit = 0; exp_miss = 0;
  endtask

  task automatic do_req(input bit p, input logic [15:0] a);
    bit h;
    int lat, r_me, r_ot, mq, ni;
    h = cfind(a) >= 0; mq = n_memreq; ni = n_ins;
    r_me = p ? n_r1 : n_r0; r_ot = p ? n_r0 : n_r1;
    @(negedge clk);
    if (p) begin req1_valid = 1; req1_adr = a; end
    else   begin req0_valid = 1; req0_adr = a; end
    #1;
    chk("grant", p ? req1_ready : req0_ready, 1);
    @(negedge clk); req0_valid = 0; req1_valid = 0; #1;
    lat = 1;
    while ((p ? n_r1 : n_r0) == r_me && lat < 100) begin @(negedge clk); #1; lat++; end
    chk("resp_count", (p ? n_r1 : n_r0) - r_me, 1);
    chk("resp_data", p ? last_r1 : last_r0, memval(a));
    chk("other_quiet", p ? n_r0 : n_r1, r_ot);
    if (h) begin
      chk("hit_latency", lat, 3);
      chk("hit_no_memreq", n_memreq, mq);
      exp_hit = sat(exp_hit);
    end else begin
      chk("miss_memreq", n_memreq, mq + 1);
      chk("miss_mem_adr", last_mreq_adr, a);
      chk("fill_count", n_ins, ni + 1);
      chk("fill_adr", last_ins_adr, a);
      chk("fill_data", last_ins_dat, memval(a));
      exp_miss = sat(exp_miss);
    end
    chk("hit_count", hit_count, exp_hit);
    chk("miss_count", miss_count, exp_miss);
  endtask

  initial begin
    int r0, r1, mq, ni, g, t, s0, e0;
    bit exp_p;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_resp0_valid", resp0_valid, 0);
    chk("rst_resp1_valid", resp1_valid, 0);
    chk("rst_resp0_data", resp0_data, 0);
    chk("rst_resp1_data", resp1_data, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_miss_count", miss_count, 0);
    chk("rst_read", c_readEnable, 0);
    chk("rst_insert", c_valid_in, 0);
    chk("rst_memreq", mem_req_valid, 0);
    @(negedge clk); rst_n = 1;

    do_req(0, 16'h0040);
    do_req(1, 16'h0040);
    chk("resp0_still_beef", resp0_data, 16'hBEEF);

    mute = 1; mq = n_memreq; ni = n_ins; r0 = n_r0;
    @(negedge clk); req0_valid = 1; req0_adr = 16'h0077; #1;
    chk("rw_grant", req0_ready, 1);
    @(negedge clk); req0_valid = 0;
    t = 0;
    while (n_memreq == mq && t < 50) begin @(negedge clk); t++; end
    chk("rw_memreq", n_memreq, mq + 1);
    rst_n = 0;
    @(negedge clk); rst_n = 1; inj_valid = 1; inj_data = 16'h1234;
    @(negedge clk); inj_valid = 0; mute = 0;
    repeat (8) @(negedge clk);
    #1;
    exp_hit = 0; exp_miss = 0;
    chk("rw_no_fill", n_ins, ni);
    chk("rw_no_resp", n_r0, r0);
    chk("rw_resp0_data", resp0_data, 0);
    chk("rw_hit_count", hit_count, 0);
    chk("rw_miss_count", miss_count, 0);
    chk("rw_idle_memreq", mem_req_valid, 0);
    chk("rw_idle_read", c_readEnable, 0);

    do_reset();
    @(negedge clk); req0_valid = 1; req0_adr = 16'h0010; req1_valid = 1; req1_adr = 16'h0020;
    r0 = n_r0; r1 = n_r1; g = 0; t = 0; exp_p = 0;
    while (g < 8 && t < 200) begin
      #1;
      if (req0_ready || req1_ready) begin
        chk("pair_excl", req0_ready && req1_ready, 0);
        chk("pair_order", req1_ready, exp_p);
        if (cfind(req1_ready ? 16'h0020 : 16'h0010) >= 0) exp_hit = sat(exp_hit);
        else exp_miss = sat(exp_miss);
        exp_p = !exp_p; g++;
      end
      @(negedge clk); t++;
    end
    req0_valid = 0; req1_valid = 0;
    chk("pair_grants", g, 8);
    t = 0;
    while ((n_r0 - r0 < 4 || n_r1 - r1 < 4) && t < 200) begin @(negedge clk); #1; t++; end
    chk("pair_resp0", n_r0 - r0, 4);
    chk("pair_resp1", n_r1 - r1, 4);
    chk("pair_data0", last_r0, memval(16'h0010));
    chk("pair_data1", last_r1, memval(16'h0020));
    chk("pair_hits", hit_count, exp_hit);
    chk("pair_misses", miss_count, exp_miss);

    stall = 5; s0 = n_stall; e0 = stab_err;
    do_req(0, 16'h0300);
    chk("stall_cycles", n_stall - s0, 5);
    chk("stall_stable", stab_err - e0, 0);
    stall = 0;

    for (int i = 0; i < 40; i++) begin
      stall = $urandom_range(0, 3);
      do_req(1'($urandom_range(0, 1)), 16'h0100 + 16'($urandom_range(0, 5)));
    end
    stall = 0;

    do_req(0, 16'h0200);
    @(negedge clk);
    force dut.r_hit_cnt = 16'hFFFD;
    #1 release dut.r_hit_cnt;
    exp_hit = 65533;
    for (int i = 0; i < 4; i++) do_req(1'($urandom_range(0, 1)), 16'h0200);
    chk("sat_hold", hit_count, 16'hFFFF);

    chk("read_insert_exclusive", excl, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
